// File: rtl/audio_dac_pkg.sv
// Shared constants for the hybrid PWM / sigma-delta audio DAC.
// Frame geometry, the input scaling and the reset state of the modulator are defined here.
package audio_dac_pkg;

    // PWM frame: 32 cycles, addressed by a 5-bit counter
    localparam int unsigned FRAME_LEN = 32;
    localparam int          CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'(FRAME_LEN - 1);

    // Input scaling: scaled = 2^27 + din * 61440.
    // 61440 = 2^16 - 2^12, so the product needs no real multiplier.
    localparam logic [31:0] SCALE_OFFSET = 32'h0800_0000;
    localparam int unsigned GAIN         = 61440;
    localparam int          GAIN_HI_SH   = 16;
    localparam int          GAIN_LO_SH   = 12;

    // Reset state of the modulator
    localparam logic [CNT_W-1:0] THR_RST   = 5'd16;
    localparam logic [15:0]      SIGMA_RST = 16'h0400;

    // Map a 16-bit offset-binary sample onto 2048..63487 in the upper half-word.
    // The offset keeps the narrowest pulse at 2 cycles, and the gain keeps the widest pulse below a full 32.
    function automatic logic [31:0] scale_sample(input logic [15:0] s);
        logic [31:0] hi_term;
        logic [31:0] lo_term;
        hi_term = {s, 16'b0};
        lo_term = {4'b0, s, 12'b0};
        return SCALE_OFFSET + (hi_term - lo_term);
    endfunction

endpackage

// File: rtl/hybrid_pwm_sd_dac_if.sv
// Sample-in / bitstream-out connection between the mixer and the DAC modulator.
interface hybrid_pwm_sd_dac_if;
    logic [15:0] din;   // unsigned sample, 0x8000 = midscale
    logic        dout;  // PWM / sigma-delta bitstream

    // Mixer side: supplies samples, observes the bitstream
    modport master (output din, input dout);
    // Modulator side
    modport slave  (input din, output dout);
endinterface

// File: rtl/hybrid_pwm_sd_dac.sv
// 1-bit audio DAC modulator. It emits a 32-cycle PWM frame with a 5-bit width.
// First-order sigma-delta dithering of that width recovers the low 11 bits of the scaled sample.
module hybrid_pwm_sd_dac
    import audio_dac_pkg::*;
(
    input  logic               mclk,
    input  logic               rst0,
    hybrid_pwm_sd_dac_if.slave bus
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] thr;
    logic [31:0]      scaled;
    logic [15:0]      sigma;
    logic             out;
    logic             frame_end;

    assign frame_end = (cnt == CNT_MAX);

    // The three-stage frame pipeline (sample -> scale -> accumulate -> width) advances once per frame.
    // The pulse is set at the frame boundary and cleared when the counter reaches the width.
    always_ff @(posedge mclk or posedge rst0) begin
        if (rst0) begin
            cnt    <= '0;
            thr    <= THR_RST;
            scaled <= '0;
            sigma  <= SIGMA_RST;
            out    <= 1'b0;
        end else begin
            cnt <= cnt + 5'd1;
            if (cnt == thr)
                out <= 1'b0;
            if (frame_end) begin
                scaled <= scale_sample(bus.din);
                // The integer part feeds the width; bits [10:0] carry over as the residual
                sigma  <= scaled[31:16] + {5'b0, sigma[10:0]};
                thr    <= sigma[15:11];
                // A set wins over the clear, so thr==31 holds dout high across the whole frame
                out    <= 1'b1;
            end
        end
    end

    // The low half of the scaled sample is below the modulator's resolution
    logic unused_scaled_lo;
    assign unused_scaled_lo = ^scaled[15:0];

    assign bus.dout = out;

endmodule

// File: tb/tb_hybrid_pwm_sd_dac.sv
// Self-checking bench for hybrid_pwm_sd_dac.
// A frame-level reference model predicts the pulse width of every frame, and each frame's 32-bit pattern is compared with it.
module tb_hybrid_pwm_sd_dac;

    logic mclk = 1'b0;
    logic rst0 = 1'b0;

    hybrid_pwm_sd_dac_if bus();

    hybrid_pwm_sd_dac dut (
        .mclk (mclk),
        .rst0 (rst0),
        .bus  (bus)
    );

    always #5 mclk = ~mclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a sample is scaled at one frame boundary and accumulated at the next.
    // Its integer part becomes the pulse width on the boundary after that.
    int     cyc;        // clock edges since reset release
    longint m_scaled;   // scaled sample waiting to be accumulated
    longint m_sigma;    // accumulator: integer part (units of 2048) + residual
    int     m_thr;      // pulse width index of the current frame

    task automatic model_reset();
        cyc      = 0;
        m_scaled = 0;
        m_sigma  = 1024;
        m_thr    = 16;
    endtask

    // One clock edge. The expected dout for the following cycle is returned.
    task automatic tick(output logic e);
        @(posedge mclk);
        cyc++;
        if (cyc % 32 == 0) begin
            m_thr    = int'(m_sigma / 2048);
            m_sigma  = m_scaled / 65536 + m_sigma % 2048;
            m_scaled = 134217728 + longint'(bus.din) * 61440;
        end
        #1;
        e = (cyc >= 32) && ((cyc % 32) <= m_thr);
    endtask

    // Advance to the last cycle of a frame
    task automatic align();
        logic e;
        while (cyc % 32 != 31) tick(e);
    endtask

    // Capture one whole frame. din optionally changes after cycle mid_at.
    task automatic run_frame(input logic [15:0] mid_din, input int mid_at,
                             output logic [31:0] act, output logic [31:0] expv);
        logic e;
        for (int i = 0; i < 32; i++) begin
            tick(e);
            act[i]  = bus.dout;
            expv[i] = e;
            if (i == mid_at) bus.din = mid_din;
        end
    endtask

    task automatic test_reset();
        logic e;
        int   first;
        bus.din = 16'h1234;
        #3 rst0 = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 1'b0) begin failures++; $display("FAIL reset_dout: got %b expected 0", bus.dout); end
        checks++;
        if (dut.cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
        for (int i = 0; i < 3; i++) begin
            bus.din = 16'($urandom);
            @(posedge mclk); #1;
            checks++;
            if (bus.dout !== 1'b0) begin failures++; $display("FAIL reset_hold: got %b expected 0", bus.dout); end
        end
        rst0 = 1'b0;
        model_reset();
        bus.din = 16'h8000;
        first = -1;
        for (int n = 0; n < 100 && first < 0; n++) begin
            tick(e);
            if (bus.dout === 1'b1) first = cyc;
        end
        checks++;
        if (first != 32) begin failures++; $display("FAIL first_rise: got edge %0d expected edge 32", first); end
    endtask

    task automatic test_midscale();
        logic [31:0] act, expv;
        bus.din = 16'h8000;
        align();
        for (int f = 0; f < 3; f++) run_frame(16'h0, 99, act, expv);
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h0, 99, act, expv);
            checks++;
            if (act !== expv) begin failures++; $display("FAIL mid_pattern: got %h expected %h", act, expv); end
            checks++;
            if ($countones(act) != 17) begin failures++; $display("FAIL mid_high: got %0d expected 17", $countones(act)); end
        end
    endtask

    task automatic test_zero();
        logic [31:0] act, expv;
        bus.din = 16'h0000;
        for (int f = 0; f < 3; f++) run_frame(16'h0, 99, act, expv);
        for (int f = 0; f < 4; f++) begin
            run_frame(16'h0, 99, act, expv);
            checks++;
            if (act !== expv) begin failures++; $display("FAIL zero_pattern: got %h expected %h", act, expv); end
            checks++;
            if ($countones(act) != 2) begin failures++; $display("FAIL zero_high: got %0d expected 2", $countones(act)); end
        end
    endtask

    task automatic test_fullscale();
        logic [31:0] act, expv;
        bus.din = 16'hFFFF;
        for (int f = 0; f < 3; f++) run_frame(16'h0, 99, act, expv);
        for (int f = 0; f < 6; f++) begin
            run_frame(16'h0, 99, act, expv);
            checks++;
            if (act !== expv) begin failures++; $display("FAIL full_pattern: got %h expected %h", act, expv); end
            checks++;
            if ($countones(act) < 31) begin failures++; $display("FAIL full_high: got %0d expected >=31", $countones(act)); end
        end
    endtask

    task automatic test_quarter();
        logic [31:0] act, expv;
        int total;
        bus.din = 16'h4000;
        for (int f = 0; f < 3; f++) run_frame(16'h0, 99, act, expv);
        total = 0;
        for (int f = 0; f < 64; f++) begin
            run_frame(16'h0, 99, act, expv);
            total += $countones(act);
            checks++;
            if (act !== expv) begin failures++; $display("FAIL quarter_pattern: got %h expected %h", act, expv); end
            checks++;
            if ($countones(act) != 9 && $countones(act) != 10) begin
                failures++; $display("FAIL quarter_width: got %0d expected 9 or 10", $countones(act));
            end
        end
        // 9.5/32 duty over 64 frames is 608 high cycles, and +-1/64 of the duty allows +-32 cycles
        checks++;
        if (total < 576 || total > 640) begin failures++; $display("FAIL quarter_mean: got %0d expected 608+-32", total); end
    endtask

    task automatic test_step_and_reset();
        logic [31:0] act, expv;
        logic e;
        bus.din = 16'h0000;
        for (int f = 0; f < 3; f++) run_frame(16'h0, 99, act, expv);
        // Step to full scale at cnt==10
        run_frame(16'hFFFF, 10, act, expv);
        checks++;
        if (act !== expv || $countones(act) != 2) begin failures++; $display("FAIL step_current: got %h expected %h", act, expv); end
        run_frame(16'h0, 99, act, expv);
        checks++;
        if (act !== expv || $countones(act) != 2) begin failures++; $display("FAIL step_next: got %h expected %h", act, expv); end
        run_frame(16'h0, 99, act, expv);
        checks++;
        if (act !== expv) begin failures++; $display("FAIL step_second: got %h expected %h", act, expv); end
        run_frame(16'h0, 99, act, expv);
        checks++;
        if (act !== expv || $countones(act) < 31) begin failures++; $display("FAIL step_third: got %h expected %h", act, expv); end
        // Pull reset in the middle of a high pulse
        for (int i = 0; i < 6; i++) tick(e);
        checks++;
        if (bus.dout !== e || e !== 1'b1) begin failures++; $display("FAIL pre_reset_high: got %b expected 1", bus.dout); end
        rst0 = 1'b1;
        #1;
        checks++;
        if (bus.dout !== 1'b0) begin failures++; $display("FAIL midpulse_reset: got %b expected 0", bus.dout); end
        checks++;
        if (dut.cnt !== 5'd0) begin failures++; $display("FAIL midpulse_cnt: got %0d expected 0", dut.cnt); end
        @(posedge mclk); #1;
        rst0 = 1'b0;
        model_reset();
        // The first frame after release stays low, and the pulse starts at edge 32
        for (int i = 0; i < 33; i++) begin
            tick(e);
            checks++;
            if (bus.dout !== e) begin failures++; $display("FAIL post_reset_cyc%0d: got %b expected %b", cyc, bus.dout, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] act, expv;
        align();
        for (int f = 0; f < 40; f++) begin
            bus.din = 16'($urandom);
            run_frame(16'($urandom), int'($urandom_range(0, 40)), act, expv);
            checks++;
            if (act !== expv) begin failures++; $display("FAIL random_frame%0d: got %h expected %h", f, act, expv); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_midscale();
        test_zero();
        test_fullscale();
        test_quarter();
        test_step_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
